alu_status_unit: RTL and testbench

ALU_STATUS_UNIT -- requirements
Module: alu_status_unit

---
 rtl/alu_status_unit.sv | 136 +++++++++++++
 tb/tb_alu_status_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/alu_status_unit.sv
// Two-entry skid FIFO between the flag calculator and the committed status
// register, plus condition-code evaluation and overflow tracking.

package alu_ops;
  localparam int unsigned ADD_OP = 0;
  localparam int unsigned SUB_OP = 1;
  localparam int unsigned AND_OP = 2;
endpackage

module alu_status_unit
  import alu_ops::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_opcode,
  input  logic [W-1:0] in_result,
  input  logic         in_negative,
  input  logic         in_zero,
  input  logic         in_overflow,
  input  logic         in_cout,
  input  logic         flush,
  input  logic         clr_sticky,
  input  logic [3:0]   cond_sel,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic [3:0]   status,
  output logic         cond_true,
  output logic         ovf_sticky,
  output logic [7:0]   ovf_count
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  typedef struct packed {
    logic [W-1:0] opcode;
    logic [W-1:0] result;
    logic         n;
    logic         z;
    logic         v;
    logic         c;
  } beat_t;

  logic [1:0] state_reg, state_next;
  beat_t      head_reg, tail_reg, in_beat;
  logic       accept, commit, cv_update, v_set;

  assign in_beat   = '{in_opcode, in_result, in_negative, in_zero, in_overflow, in_cout};
  assign in_ready  = (state_reg != TWO);
  assign out_valid = (state_reg != EMPTY);
  assign out_result = head_reg.result;
  assign accept    = in_valid && in_ready;
  assign commit    = out_valid && out_ready;
  assign cv_update = (head_reg.opcode == W'(ADD_OP)) || (head_reg.opcode == W'(SUB_OP));
  assign v_set     = commit && cv_update && head_reg.v;

  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = EMPTY;
    end else if (accept && !commit) begin
      state_next = (state_reg == EMPTY) ? ONE : TWO;
    end else if (commit && !accept) begin
      state_next = (state_reg == TWO) ? ONE : EMPTY;
    end
  end

  // Head always sits in head_reg; the tail shifts forward when the head commits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= EMPTY;
      head_reg  <= '0;
      tail_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (!flush) begin
        if (commit && accept) begin
          head_reg <= in_beat;
        end else if (commit) begin
          head_reg <= tail_reg;
        end else if (accept) begin
          if (state_reg == EMPTY) head_reg <= in_beat;
          else                    tail_reg <= in_beat;
        end
      end
    end
  end

  // Commits still land during a flush cycle; only the buffer is discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status     <= 4'b0000;
      ovf_sticky <= 1'b0;
      ovf_count  <= 8'd0;
    end else begin
      if (commit) begin
        status[3] <= head_reg.n;
        status[2] <= head_reg.z;
        if (cv_update) begin
          status[1] <= head_reg.c;
          status[0] <= head_reg.v;
        end
      end
      if (clr_sticky) begin
        ovf_sticky <= v_set;
        ovf_count  <= v_set ? 8'd1 : 8'd0;
      end else if (v_set) begin
        ovf_sticky <= 1'b1;
        if (ovf_count != 8'd255) ovf_count <= ovf_count + 8'd1;
      end
    end
  end

  always_comb begin
    cond_true = 1'b0;
    case (cond_sel)
      4'd0: cond_true = status[2];
      4'd1: cond_true = !status[2];
      4'd2: cond_true = status[1];
      4'd3: cond_true = !status[1];
      4'd4: cond_true = status[3];
      4'd5: cond_true = !status[3];
      4'd6: cond_true = status[0];
      4'd7: cond_true = !status[0];
      4'd8: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_alu_status_unit.sv
// Directed bench for alu_status_unit: buffering, status commit, conditions,
// overflow tracking, flush and asynchronous reset.

module tb_alu_status_unit;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [W-1:0] in_opcode, in_result;
  logic         in_negative, in_zero, in_overflow, in_cout;
  logic         flush, clr_sticky;
  logic [3:0]   cond_sel;
  logic         out_valid, out_ready;
  logic [W-1:0] out_result;
  logic [3:0]   status;
  logic         cond_true, ovf_sticky;
  logic [7:0]   ovf_count;

  int passed = 0;
  int total  = 0;

  alu_status_unit #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_result(in_result),
    .in_negative(in_negative), .in_zero(in_zero),
    .in_overflow(in_overflow), .in_cout(in_cout),
    .flush(flush), .clr_sticky(clr_sticky), .cond_sel(cond_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .status(status), .cond_true(cond_true),
    .ovf_sticky(ovf_sticky), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [W-1:0] op, input logic [W-1:0] res,
                          input logic n, input logic z, input logic v, input logic c);
    in_valid = 1'b1; in_opcode = op; in_result = res;
    in_negative = n; in_zero = z; in_overflow = v; in_cout = c;
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; in_opcode = 0; in_result = 0;
    in_negative = 0; in_zero = 0; in_overflow = 0; in_cout = 0;
    flush = 0; clr_sticky = 0; cond_sel = 4'd8; out_ready = 0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_result", out_result, 0);
    check("rst_status", status, 4'b0000);
    check("rst_sticky", ovf_sticky, 0);
    check("rst_count", ovf_count, 0);
    check("rst_cond_al", cond_true, 1);
    cond_sel = 4'd1; #1;
    check("rst_cond_ne", cond_true, 1);
    rst = 1'b0;

    // ADD result 0 with carry: visible one cycle after accept, then committed
    out_ready = 1;
    set_beat(4'd0, 4'd0, 0, 1, 0, 1);
    tick(); in_valid = 0;
    check("add_out_valid", out_valid, 1);
    check("add_out_result", out_result, 0);
    tick();
    check("add_status", status, 4'b0110);
    check("add_drained", out_valid, 0);
    cond_sel = 4'd0; #1;
    check("add_cond_eq", cond_true, 1);
    cond_sel = 4'd2; #1;
    check("add_cond_cs", cond_true, 1);

    // Backpressure: third beat must be held off, order preserved
    out_ready = 0;
    set_beat(4'd2, 4'd5, 0, 0, 0, 0);
    tick();
    check("bp_ready_one", in_ready, 1);
    set_beat(4'd2, 4'd6, 0, 0, 0, 0);
    tick();
    check("bp_ready_two", in_ready, 0);
    check("bp_head_5", out_result, 5);
    set_beat(4'd2, 4'd7, 0, 0, 0, 0);
    tick();
    check("bp_head_held", out_result, 5);
    check("bp_still_full", in_ready, 0);
    in_valid = 0; out_ready = 1;
    tick();
    check("bp_head_6", out_result, 6);
    check("bp_ready_again", in_ready, 1);
    tick();
    check("bp_empty", out_valid, 0);
    check("bp_status_cv_hold", status, 4'b0010);

    // SUB with overflow, then a logic op must not touch C/V
    set_beat(4'd1, 4'd8, 1, 0, 1, 0);
    tick(); in_valid = 0;
    tick();
    check("sub_status", status, 4'b1001);
    check("sub_count", ovf_count, 1);
    check("sub_sticky", ovf_sticky, 1);
    set_beat(4'd2, 4'd3, 0, 0, 0, 0);
    tick(); in_valid = 0;
    tick();
    check("and_status", status, 4'b0001);
    check("and_count", ovf_count, 1);
    cond_sel = 4'd6; #1;
    check("and_cond_vs", cond_true, 1);
    cond_sel = 4'd3; #1;
    check("and_cond_cc", cond_true, 1);
    cond_sel = 4'd9; #1;
    check("cond_reserved", cond_true, 0);

    // clr alone, then 300 overflow commits saturate at 255
    clr_sticky = 1;
    tick(); clr_sticky = 0;
    check("clr_count", ovf_count, 0);
    check("clr_sticky", ovf_sticky, 0);
    set_beat(4'd0, 4'd1, 0, 0, 1, 0);
    for (int i = 0; i < 300; i++) tick();
    in_valid = 0;
    tick();
    check("sat_count", ovf_count, 255);
    check("sat_sticky", ovf_sticky, 1);
    set_beat(4'd0, 4'd1, 0, 0, 1, 0);
    tick(); in_valid = 0; clr_sticky = 1;
    tick(); clr_sticky = 0;
    check("clr_with_ovf_count", ovf_count, 1);
    check("clr_with_ovf_sticky", ovf_sticky, 1);

    // Flush from TWO: head still commits, buffer and incoming beat dropped
    out_ready = 0;
    set_beat(4'd0, 4'd10, 1, 0, 0, 0);
    tick();
    set_beat(4'd0, 4'd11, 0, 1, 0, 1);
    tick();
    check("fl_full", in_ready, 0);
    set_beat(4'd0, 4'd12, 0, 0, 1, 1);
    flush = 1; out_ready = 1;
    tick(); flush = 0; in_valid = 0;
    check("fl_out_valid", out_valid, 0);
    check("fl_in_ready", in_ready, 1);
    check("fl_status", status, 4'b1000);
    check("fl_count", ovf_count, 1);
    tick();
    check("fl_no_new_beat", out_valid, 0);

    // Async reset between edges while one beat is buffered
    out_ready = 0;
    set_beat(4'd1, 4'd4, 0, 1, 1, 1);
    tick(); in_valid = 0;
    check("ar_one", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("ar_out_valid", out_valid, 0);
    check("ar_status", status, 4'b0000);
    check("ar_in_ready", in_ready, 1);
    check("ar_count", ovf_count, 0);
    #1 rst = 1'b0;
    out_ready = 1;
    tick();
    check("ar_no_commit", status, 4'b0000);
    check("ar_still_empty", out_valid, 0);
    set_beat(4'd2, 4'd9, 0, 0, 0, 0);
    tick(); in_valid = 0;
    check("ar_first_accept", out_result, 9);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
